pwm_duty_meter: RTL

Measures the duty cycle and period of a single PWM input and reports them as 8-bit brightness codes and cycle counts. It is the receive-side counterpart of the LED PWM generators: a free-running 256-cycle PWM driven with threshold T reads back as duty T. It sits between an external or looped-back PWM pin and the display/debug logic, and flags a stuck line.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_duty_meter_sync_edge.sv | 33 +++
 rtl/pwm_duty_meter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / meter family: meter FSM encoding
// and the default resolution, period width and stuck-line timeout.
package pwm_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } meter_state_t;

  localparam int DUTY_W_DEF      = 8;
  localparam int PER_W_DEF       = 16;
  localparam int TIMEOUT_DEF     = 65535;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pwm_duty_meter_sync_edge.sv
// Brings an asynchronous line into the clock domain and derives single-cycle
// rise/fall pulses from the synchronized level and its one-cycle delay.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_s & ~r_s_d;
  assign o_fall = ~o_s & r_s_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// Receive-side PWM meter: duty over a fixed 2^DUTY_W window, rise-to-rise
// period, lock indication and stuck-high/stuck-low detection.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int PER_W       = PER_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [PER_W-1:0]  period,
  output logic              period_valid,
  output logic              locked,
  output logic              stuck_hi,
  output logic              stuck_lo
);

  localparam int                 IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [PER_W-1:0]   PER_MAX  = '1;
  localparam logic [DUTY_W-1:0]  WIN_LAST = '1;

  logic w_s;
  logic w_rise;
  logic w_fall;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (CLOCK_50),
    .i_rst_n(RESET_N),
    .i_async(pwm_in),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Duty window
  logic [DUTY_W-1:0] r_win_cnt;
  logic [DUTY_W:0]   r_hi_cnt;
  logic [DUTY_W:0]   w_hi_sum;
  logic [DUTY_W-1:0] r_duty;
  logic              r_duty_valid;

  assign w_hi_sum = r_hi_cnt + {{DUTY_W{1'b0}}, w_s};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_win_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
      if (r_win_cnt == WIN_LAST) begin
        // Only a fully high window reaches 2^DUTY_W; clamp it to the top code.
        r_duty       <= w_hi_sum[DUTY_W] ? WIN_LAST : w_hi_sum[DUTY_W-1:0];
        r_duty_valid <= 1'b1;
        r_hi_cnt     <= '0;
      end else begin
        r_hi_cnt     <= w_hi_sum;
        r_duty_valid <= 1'b0;
      end
    end
  end

  // Period / idle counters
  logic [PER_W-1:0]  r_per_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_timeout;

  assign w_timeout = (r_idle_cnt == IDLE_MAX);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_per_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_rise)                  r_per_cnt <= PER_W'(1);
      else if (r_per_cnt != PER_MAX) r_per_cnt <= r_per_cnt + 1'b1;

      if (w_rise || w_fall) r_idle_cnt <= IDLE_W'(1);
      else if (!w_timeout)  r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Period FSM
  meter_state_t     r_state;
  logic [PER_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_stuck_hi;
  logic             r_stuck_lo;
  logic             w_go_stuck;

  // A rise coinciding with the timeout keeps the line alive.
  assign w_go_stuck = (r_state != STUCK) && w_timeout && !w_rise;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= SEARCH;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_stuck_hi     <= 1'b0;
      r_stuck_lo     <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (w_go_stuck) begin
        r_state    <= STUCK;
        r_locked   <= 1'b0;
        r_stuck_hi <= w_s;
        r_stuck_lo <= ~w_s;
      end else begin
        case (r_state)
          SEARCH: begin
            if (w_rise) r_state <= MEASURE;
          end
          MEASURE: begin
            if (w_rise) begin
              r_period       <= r_per_cnt;
              r_period_valid <= 1'b1;
              r_locked       <= 1'b1;
            end
          end
          STUCK: begin
            if (w_rise || w_fall) begin
              r_state    <= w_rise ? MEASURE : SEARCH;
              r_stuck_hi <= 1'b0;
              r_stuck_lo <= 1'b0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign duty         = r_duty;
  assign duty_valid   = r_duty_valid;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign stuck_hi     = r_stuck_hi;
  assign stuck_lo     = r_stuck_lo;

endmodule
